// File: rtl/proj_histogram_stream.sv
// rtl/proj_histogram_stream.sv - x/y projection histogram with clear sweep and valid/ready readout
// Define PROJ_HIST_CLEAR_ON_READ_EN to zero each bin as its readout beat is accepted.
module proj_histogram_stream #(
  parameter int IMG_W = 240,
  parameter int IMG_H = 180,
  parameter int CNT_W = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_start,
  input  logic             pix_valid,
  input  logic [AW-1:0]    pix_x,
  input  logic [AW-1:0]    pix_y,
  input  logic             pix_data,
  input  logic             read_start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_axis,
  output logic [AW-1:0]    out_index,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             sat_flag
);

  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);
  localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 1);
  localparam logic [AW-1:0] C_LAST = AW'(MAXD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef PROJ_HIST_CLEAR_ON_READ_EN
  localparam bit CLR_ON_RD = 1'b1;
`else
  localparam bit CLR_ON_RD = 1'b0;
`endif

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_READ} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] x_mem [IMG_W];
  logic [CNT_W-1:0] y_mem [IMG_H];

  logic [AW-1:0]    clr_idx;
  logic             fetch;
  logic             accept;
  logic             hit, x_hit, y_hit, sat_hit;
  logic [CNT_W-1:0] x_cur, y_cur;
  logic             x_we, y_we;
  logic [AW-1:0]    x_wa, y_wa;
  logic [CNT_W-1:0] x_wd, y_wd;
  logic             nxt_axis;
  logic [AW-1:0]    nxt_idx;
  logic [CNT_W-1:0] nxt_cnt;

  assign accept = out_valid && out_ready;
  assign busy   = (state != S_ACCUM);

  // Single-cycle read-modify-write: a same-address pixel on the next cycle sees the updated bin.
  always_comb begin
    hit     = (state == S_ACCUM) && pix_valid && pix_data;
    x_hit   = hit && (pix_x <= X_LAST);
    y_hit   = hit && (pix_y <= Y_LAST);
    x_cur   = x_mem[pix_x];
    y_cur   = y_mem[pix_y];
    sat_hit = (x_hit && (x_cur == CNT_MAX)) || (y_hit && (y_cur == CNT_MAX));
  end

  always_comb begin
    x_we = 1'b0;
    y_we = 1'b0;
    x_wa = pix_x;
    y_wa = pix_y;
    x_wd = (x_cur == CNT_MAX) ? x_cur : x_cur + 1'b1;
    y_wd = (y_cur == CNT_MAX) ? y_cur : y_cur + 1'b1;
    case (state)
      S_CLEAR: begin
        x_we = (clr_idx <= X_LAST);
        y_we = (clr_idx <= Y_LAST);
        x_wa = clr_idx;
        y_wa = clr_idx;
        x_wd = '0;
        y_wd = '0;
      end
      S_ACCUM: begin
        x_we = x_hit;
        y_we = y_hit;
      end
      S_READ: begin
        if (CLR_ON_RD && accept) begin
          x_we = !out_axis;
          y_we = out_axis;
          x_wa = out_index;
          y_wa = out_index;
          x_wd = '0;
          y_wd = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_we) x_mem[x_wa] <= x_wd;
    if (y_we) y_mem[y_wa] <= y_wd;
  end

  // Address of the beat to load next: first beat after fetch, else successor of the current one.
  always_comb begin
    nxt_axis = out_axis;
    nxt_idx  = out_index + 1'b1;
    if (fetch) begin
      nxt_axis = 1'b0;
      nxt_idx  = '0;
    end else if (!out_axis && (out_index == X_LAST)) begin
      nxt_axis = 1'b1;
      nxt_idx  = '0;
    end
    nxt_cnt = nxt_axis ? y_mem[nxt_idx] : x_mem[nxt_idx];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_idx == C_LAST) state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (clear_start)     state_nxt = S_CLEAR;
        else if (read_start) state_nxt = S_READ;
      end
      S_READ:  if (accept && out_last) state_nxt = S_ACCUM;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx   <= '0;
      fetch     <= 1'b0;
      out_valid <= 1'b0;
      out_axis  <= 1'b0;
      out_index <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      clr_idx <= (state == S_CLEAR) ? clr_idx + 1'b1 : '0;
      fetch   <= (state == S_ACCUM) && (state_nxt == S_READ);

      if (state == S_CLEAR)
        sat_flag <= 1'b0;
      else if (sat_hit)
        sat_flag <= 1'b1;
      else if (CLR_ON_RD && (state == S_READ) && (state_nxt == S_ACCUM))
        sat_flag <= 1'b0;

      if (fetch || (accept && !out_last)) begin
        out_valid <= 1'b1;
        out_axis  <= nxt_axis;
        out_index <= nxt_idx;
        out_count <= nxt_cnt;
        out_last  <= nxt_axis && (nxt_idx == Y_LAST);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_axis  <= 1'b0;
        out_index <= '0;
        out_count <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proj_histogram_stream.sv
// tb/tb_proj_histogram_stream.sv - self-checking bench for proj_histogram_stream
module tb_proj_histogram_stream;

  localparam int W = 240;
  localparam int H = 180;
  localparam int N = W + H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_x = '0;
  logic [7:0] pix_y = '0;
  logic       pix_data = 1'b0;
  logic       read_start = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, out_valid, out_axis, out_last, sat_flag;
  logic [7:0] out_index, out_count;

  int n_checks = 0;
  int n_pass = 0;
  int xm [W];
  int ym [H];
  bit sat_m;

  always #5 clk = ~clk;

  proj_histogram_stream dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .read_start(read_start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_axis(out_axis), .out_index(out_index), .out_count(out_count),
    .out_last(out_last), .sat_flag(sat_flag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    foreach (xm[i]) xm[i] = 0;
    foreach (ym[i]) ym[i] = 0;
    sat_m = 1'b0;
  endtask

  task automatic send(input int x, input int y, input bit d);
    pix_valid = 1'b1;
    pix_x     = x[7:0];
    pix_y     = y[7:0];
    pix_data  = d;
    if (d) begin
      if (x < W) begin
        if (xm[x] == 255) sat_m = 1'b1;
        else xm[x]++;
      end
      if (y < H) begin
        if (ym[y] == 255) sat_m = 1'b1;
        else ym[y]++;
      end
    end
    step();
  endtask

  task automatic jam();
    pix_valid   = 1'($urandom_range(0, 1));
    pix_x       = 8'($urandom);
    pix_y       = 8'($urandom);
    pix_data    = 1'b1;
    clear_start = ($urandom_range(0, 15) == 0);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_busy_cycles"}, n, 240);
    check({tag, "_sat_clear"}, sat_flag, 0);
  endtask

  task automatic do_read(input string tag, input bit bp, input bit noise);
    int lat = 0;
    int k = 0;
    int errs = 0;
    int stall_errs = 0;
    int cyc = 0;
    int e_idx, e_cnt;
    bit e_axis;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [17:0] held = '0;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (noise) jam();
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    while (!done && cyc < 20000) begin
      if (stalled && ({out_valid, out_axis, out_index, out_count, out_last} !== {1'b1, held}))
        stall_errs++;
      if (!out_valid) begin
        if (out_count !== 8'd0) errs++;
      end else if (k >= N) begin
        errs++;
      end else begin
        e_axis = (k >= W);
        e_idx  = e_axis ? k - W : k;
        e_cnt  = e_axis ? ym[e_idx] : xm[e_idx];
        if ({out_axis, out_index, out_count, out_last} !== {e_axis, e_idx[7:0], e_cnt[7:0], k == N - 1})
          errs++;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) jam();
      stalled = out_valid && !out_ready;
      held    = {out_axis, out_index, out_count, out_last};
      if (out_valid && out_ready) begin
        k++;
        done = out_last;
      end
      step();
      cyc++;
    end
    pix_valid   = 1'b0;
    clear_start = 1'b0;
    out_ready   = 1'b1;
    check({tag, "_beats"}, k, N);
    check({tag, "_beat_errors"}, errs, 0);
    check({tag, "_stall_errors"}, stall_errs, 0);
    check({tag, "_valid_after"}, out_valid, 0);
    check({tag, "_busy_after"}, busy, 0);
`ifdef PROJ_HIST_CLEAR_ON_READ_EN
    model_clear();
`endif
    check({tag, "_sat_flag"}, sat_flag, sat_m);
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", busy, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_axis", out_axis, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    reset = 1'b0;
    model_clear();
    wait_clear("post_reset");
    do_read("empty", 1'b0, 1'b0);

    send(10, 20, 1'b1);
    pix_valid = 1'b0;
    do_read("single", 1'b0, 1'b0);

    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    model_clear();
    wait_clear("clear_cmd");

    repeat (5) send(7, 7, 1'b1);
    send(7, 7, 1'b0);
    pix_valid = 1'b0;
    do_read("burst", 1'b0, 1'b0);

    repeat (300) send(0, 0, 1'b1);
    send(239, 200, 1'b1);
    pix_valid = 1'b0;
    check("sat_flag_set", sat_flag, 1);
    do_read("saturate", 1'b0, 1'b0);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        step();
      end else begin
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
    end
    pix_valid = 1'b0;
    do_read("rand_bp", 1'b1, 1'b1);
    do_read("reread", 1'b1, 1'b0);

    clear_start = 1'b1;
    read_start  = 1'b1;
    step();
    clear_start = 1'b0;
    read_start  = 1'b0;
    model_clear();
    wait_clear("priority");

    send(5, 5, 1'b1);
    send(200, 100, 1'b1);
    pix_valid  = 1'b0;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    repeat (30) step();
    check("midread_valid", out_valid, 1);
    reset = 1'b1;
    step();
    check("midread_reset_valid", out_valid, 0);
    check("midread_reset_busy", busy, 1);
    reset = 1'b0;
    model_clear();
    wait_clear("midread_reset");
    do_read("after_reset", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
